// File: rtl/lenet_pkg.sv
// ---------------------------------------------------------------------------
// lenet_pkg
//
// Purpose:
//    Shared definitions for the LeNet datapath blocks: FP16 word geometry,
//    the stream-controller state type and the FP16 ReLU helper that both
//    Activation_ReLU and fmap_stream_out apply to outgoing words.
//
// Contents:
//    FP16_W          FP16 word width (16)
//    FP16_SIGN       bit index of the FP16 sign bit
//    stream_state_e  IDLE / STREAM controller states
//    fp16_relu()     clamps any word with the sign bit set to +0
// ---------------------------------------------------------------------------
package lenet_pkg;

   localparam int FP16_W    = 16;
   localparam int FP16_SIGN = FP16_W - 1;

   typedef enum logic {
      IDLE,
      STREAM
   } stream_state_e;

   // Only the sign bit is inspected, so -0, negative numbers and negative
   // NaNs all become +0 while +Inf and positive NaNs pass through untouched.
   function automatic logic [FP16_W-1:0] fp16_relu(input logic [FP16_W-1:0] word);
      return word[FP16_SIGN] ? '0 : word;
   endfunction

endpackage

// File: rtl/fmap_elem_sel.sv
// ---------------------------------------------------------------------------
// fmap_elem_sel
//
// Purpose:
//    Combinational element selector for a flattened feature map. Picks the
//    element at index idx out of fmap_in (element i lives in bits
//    [i*DATA_WIDTH +: DATA_WIDTH]) and optionally applies ReLU to it.
//
// Configuration:
//    FMAP_STREAM_RELU_EN  when defined, words with the sign bit set are
//                         replaced by zero; otherwise words pass bit-exact.
//
// Ports:
//    fmap_in  in   N*DATA_WIDTH  flattened feature map
//    idx      in   IDX_W         element index, expected in 0..N-1
//    word     out  DATA_WIDTH    selected (and optionally rectified) element
// ---------------------------------------------------------------------------
module fmap_elem_sel
   import lenet_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int N          = 4704,
   parameter int IDX_W      = $clog2(N)
) (
   input  logic [N*DATA_WIDTH-1:0] fmap_in,
   input  logic [IDX_W-1:0]        idx,
   output logic [DATA_WIDTH-1:0]   word
);

   // The bit offset is computed at exactly the width needed to address the
   // whole bus, so the part-select index carries no surplus bits.
   localparam int SEL_W = $clog2(N * DATA_WIDTH);

   logic [SEL_W-1:0]      bit_base;
   logic [DATA_WIDTH-1:0] raw_word;

   always_comb begin
      bit_base = SEL_W'(idx) * SEL_W'(DATA_WIDTH);
      raw_word = fmap_in[bit_base +: DATA_WIDTH];
   end

`ifdef FMAP_STREAM_RELU_EN
   // FP16 words reuse the shared helper; other widths use the same rule on
   // their own top bit.
   if (DATA_WIDTH == FP16_W) begin : g_relu_fp16
      assign word = fp16_relu(raw_word);
   end else begin : g_relu_generic
      assign word = raw_word[DATA_WIDTH-1] ? '0 : raw_word;
   end
`else
   assign word = raw_word;
`endif

endmodule

// File: rtl/fmap_stream_out.sv
// ---------------------------------------------------------------------------
// fmap_stream_out
//
// Purpose:
//    Serialises a flattened H*W*CHANNEL feature map onto a valid/ready
//    stream, one element per accepted beat, in flat bus order.
//
// Configuration:
//    FMAP_STREAM_RELU_EN  when defined, ReLU is applied to each element in
//                         the same register stage (see fmap_elem_sel).
//
// Ports:
//    clk      in   1             rising-edge clock
//    rst_n    in   1             asynchronous active-low reset
//    start    in   1             begin streaming; honoured only when idle
//    fmap_in  in   N*DATA_WIDTH  feature map, stable from start until done
//    busy     out  1             high while streaming
//    done     out  1             one-cycle pulse after the final beat
//    m_data   out  DATA_WIDTH    current element
//    m_valid  out  1             m_data is valid
//    m_ready  in   1             downstream accepts the current beat
//    m_last   out  1             current element is index N-1
//    m_index  out  IDX_W         index of the current element
// ---------------------------------------------------------------------------
module fmap_stream_out
   import lenet_pkg::*;
#(
   parameter  int DATA_WIDTH = 16,
   parameter  int H          = 28,
   parameter  int W          = 28,
   parameter  int CHANNEL    = 6,
   localparam int N          = H * W * CHANNEL,
   localparam int IDX_W      = $clog2(N)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [N*DATA_WIDTH-1:0] fmap_in,
   output logic                    busy,
   output logic                    done,
   output logic [DATA_WIDTH-1:0]   m_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic                    m_last,
   output logic [IDX_W-1:0]        m_index
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   stream_state_e         state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  last_q, last_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic [IDX_W-1:0]      sel_idx;
   logic [DATA_WIDTH-1:0] sel_word;

   // The mux always looks at the element that would be loaded on the next
   // edge: element 0 when idle, idx_q+1 while streaming. On the final beat
   // it falls back to 0 so the select never points past the bus.
   always_comb begin
      sel_idx = '0;
      if (state_q == STREAM && idx_q != LAST_IDX) begin
         sel_idx = idx_q + IDX_W'(1);
      end
   end

   fmap_elem_sel #(
      .DATA_WIDTH (DATA_WIDTH),
      .N          (N),
      .IDX_W      (IDX_W)
   ) u_elem_sel (
      .fmap_in (fmap_in),
      .idx     (sel_idx),
      .word    (sel_word)
   );

   // Next-state logic. Outputs are held by default, so a stalled beat keeps
   // data, index and last frozen; done is a pulse and defaults low.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = STREAM;
               busy_d  = 1'b1;
               valid_d = 1'b1;
               idx_d   = '0;
               data_d  = sel_word;
               last_d  = (N == 1);
            end
         end
         STREAM: begin
            if (m_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  idx_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  idx_d  = sel_idx;
                  data_d = sel_word;
                  last_d = (sel_idx == LAST_IDX);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Single register stage for the controller state and every output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign m_data  = data_q;
   assign m_valid = valid_q;
   assign m_last  = last_q;
   assign m_index = idx_q;

endmodule
